// File: rtl/div_pkg.sv
// div_pkg: shared types and helpers for the non-restoring divider
package div_pkg;
  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} div_state_t;
  localparam int W_MAX = 64;
  localparam logic [W_MAX-1:0] DZ_QUOT = '1;
  function automatic logic [W_MAX-1:0] abs_n(input logic [W_MAX-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction
endpackage

// File: rtl/nr_div_step.sv
// nr_div_step: one combinational radix-2 non-restoring iteration
module nr_div_step #(
  parameter int C_NUM_BITS = 24
) (
  input  logic [C_NUM_BITS:0]   p,
  input  logic [C_NUM_BITS-1:0] qsr,
  input  logic [C_NUM_BITS-1:0] bm,
  output logic [C_NUM_BITS:0]   p_n,
  output logic [C_NUM_BITS-1:0] qsr_n
);
  logic [C_NUM_BITS:0] p_s;
  assign p_s   = {p[C_NUM_BITS-1:0], qsr[C_NUM_BITS-1]};
  assign p_n   = p[C_NUM_BITS] ? p_s + {1'b0, bm} : p_s - {1'b0, bm};
  assign qsr_n = {qsr[C_NUM_BITS-2:0], ~p_n[C_NUM_BITS]};
endmodule

// File: rtl/seq_divider_nr.sv
// seq_divider_nr: multi-cycle signed/unsigned non-restoring divider with start/valid handshake
module seq_divider_nr
  import div_pkg::*;
#(
  parameter int C_NUM_BITS = 24,
  parameter int C_CNT_BITS = $clog2(C_NUM_BITS + 1)
) (
  input  logic                  CK,
  input  logic                  R,
  input  logic                  E,
  input  logic                  START,
  input  logic                  SGN,
  input  logic [C_NUM_BITS-1:0] A,
  input  logic [C_NUM_BITS-1:0] B,
  output logic                  BUSY,
  output logic                  VALID,
  output logic [C_NUM_BITS-1:0] Q,
  output logic [C_NUM_BITS-1:0] REM,
  output logic                  DZ
);
  localparam int N = C_NUM_BITS;
  div_state_t state;
  logic [N-1:0] a_r, b_r, bm, qsr, qsr_n, q_fix, r_src, r_fix;
  logic [N:0] p, p_n;
  logic [C_CNT_BITS-1:0] cnt;
  logic sgn_r, sa, sb, dz_r, b_zero;
  nr_div_step #(.C_NUM_BITS(N)) u_step (
    .p(p),
    .qsr(qsr),
    .bm(bm),
    .p_n(p_n),
    .qsr_n(qsr_n)
  );
  always_comb begin
    b_zero = b_r == '0;
    r_src  = p[N] ? p[N-1:0] + bm : p[N-1:0];
    q_fix  = N'(abs_n(W_MAX'(qsr), sa ^ sb));
    r_fix  = N'(abs_n(W_MAX'(r_src), sa));
  end
  always_ff @(posedge CK) begin
    if (R) begin
      state <= IDLE;
      cnt   <= '0;
      BUSY  <= 1'b0;
      VALID <= 1'b0;
      Q     <= '0;
      REM   <= '0;
      DZ    <= 1'b0;
    end else if (E) begin
      case (state)
        IDLE: if (START) begin
          a_r   <= A;
          b_r   <= B;
          sgn_r <= SGN;
          BUSY  <= 1'b1;
          state <= PREP;
        end
        PREP: begin
          sa    <= sgn_r & a_r[N-1];
          sb    <= sgn_r & b_r[N-1];
          bm    <= N'(abs_n(W_MAX'(b_r), sgn_r & b_r[N-1]));
          qsr   <= N'(abs_n(W_MAX'(a_r), sgn_r & a_r[N-1]));
          p     <= '0;
          dz_r  <= b_zero;
          cnt   <= b_zero ? '0 : C_CNT_BITS'(N);
          state <= b_zero ? FIX : CALC;
        end
        CALC: begin
          p     <= p_n;
          qsr   <= qsr_n;
          cnt   <= cnt - 1'b1;
          state <= cnt == C_CNT_BITS'(1) ? FIX : CALC;
        end
        FIX: begin
          VALID <= 1'b1;
          Q     <= dz_r ? N'(DZ_QUOT) : q_fix;
          REM   <= dz_r ? a_r : r_fix;
          DZ    <= dz_r;
          state <= DONE;
        end
        DONE: begin
          VALID <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/seq_divider_nr.md
Name: seq_divider_nr

Overview:
- Multi-cycle radix-2 non-restoring integer divider producing quotient and remainder. It is the parametrised successor of the fixed 24-bit shift-register divider.
- Adds start/valid handshake, a busy indication, signed and unsigned modes, divide-by-zero detection and a remainder output.
- Sits beside the datapath ALU. Software-visible results follow the RISC-V DIV/DIVU/REM/REMU rules.

Parameters:
- C_NUM_BITS, 24, operand, quotient and remainder width; legal range ≥ 2.
- C_CNT_BITS, $clog2(C_NUM_BITS+1), iteration counter width; derived, not to be overridden.

Ports:
- CK  in  1  clock, rising edge.
- R  in  1  reset, synchronous, active-high.
- E  in  1  enable; when low, all state holds (FSM, counter, registers, outputs).
- START  in  1  request; sampled only in IDLE with E=1.
- SGN  in  1  1 = signed two's-complement operation; captured with START.
- A  in  C_NUM_BITS  dividend; captured with START.
- B  in  C_NUM_BITS  divisor; captured with START.
- BUSY  out  1  high in every state except IDLE.
- VALID  out  1  one-cycle pulse when Q/REM/DZ are updated.
- Q  out  C_NUM_BITS  quotient; holds until the next VALID.
- REM  out  C_NUM_BITS  remainder; holds until the next VALID.
- DZ  out  1  divide-by-zero flag for the last result; holds until the next VALID.

Behaviour:
- Reset (R=1 at a rising CK edge): FSM to IDLE, counter 0, BUSY=0, VALID=0, Q=0, REM=0, DZ=0. R overrides E and aborts any operation in flight; no VALID is produced for an aborted operation.
- E=0 freezes everything, including a VALID pulse, which is then extended until the next E=1 edge. Latencies below are counted in enabled edges.
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE: BUSY=0. With START=1, capture A, B, SGN, then go to PREP.
- PREP: record sign bits sa and sb (both 0 when SGN=0) and convert the captured operands to magnitudes.
  - If B==0: go to DONE with Q=all-ones, REM=A (original), DZ=1.
  - Otherwise: clear the partial remainder (width C_NUM_BITS+1), load the magnitude of A into the quotient shift register, set counter=C_NUM_BITS, go to CALC.
- CALC, one iteration per edge:
  - Shift {P,Qsr} left by 1.
  - If P ≥ 0, P = P − |B|; else P = P + |B|.
  - The new Qsr LSB = ~P[sign].
  - Decrement the counter. At 1 → 0, go to FIX.
- FIX:
  - If P < 0, P = P + |B|.
  - Quotient = sa^sb ? −Qsr : Qsr.
  - Remainder = sa ? −P : P, truncated to C_NUM_BITS.
  - Go to DONE.
- DONE: drive VALID=1 for one cycle and update Q, REM, DZ (DZ=0 on non-zero divisor). Return to IDLE on the next edge.
- Latency: VALID is high in the cycle after edge n+C_NUM_BITS+2, where edge n samples START. That is C_NUM_BITS+3 edges from START to VALID. Divide-by-zero takes 3 edges.
- Signed overflow (−2^(N−1) / −1) needs no special case: the magnitude path yields Q=−2^(N−1) (0x800000 at N=24) and REM=0.
- START outside IDLE is ignored, with no queuing. START in the DONE cycle is ignored; the earliest accept is the cycle after VALID.
- All arithmetic is modulo 2^C_NUM_BITS on outputs. The internal P is one bit wider to hold the sign.

Decomposition:
- Package div_pkg:
  - state enum div_state_t {IDLE, PREP, CALC, FIX, DONE}.
  - Function abs_n (conditional two's-complement negate).
  - Constant for the divide-by-zero quotient (all-ones).
- One sub-module, nr_div_step: combinational single iteration.
  - Inputs: P, Qsr, |B|.
  - Outputs: next P, next Qsr.
  - Parametrised by C_NUM_BITS.
- The FSM and registers stay in seq_divider_nr.

Test Plan:
- Unsigned basic, N=24: SGN=0, A=100, B=7, START for 1 cycle → VALID exactly 27 edges later; Q=14, REM=2, DZ=0; BUSY high for 26 cycles before VALID.
- Signed mixed signs: SGN=1, A=0xFFFFF9 (−7), B=2 → Q=0xFFFFFD (−3), REM=0xFFFFFF (−1). Also A=7, B=0xFFFFFE → Q=0xFFFFFD, REM=1.
- Divide-by-zero: A=5, B=0, SGN=0 → VALID 3 edges after START; Q=0xFFFFFF, REM=5, DZ=1. Next op 9/3 → DZ=0, Q=3, REM=0.
- Signed overflow: SGN=1, A=0x800000, B=0xFFFFFF → Q=0x800000, REM=0.
- Handshake and stall:
  - START held high through an operation → exactly one result, then a second accept only after VALID.
  - E=0 for 5 cycles mid-CALC → VALID delayed by exactly 5 cycles, correct result.
- Reset mid-operation: R=1 for 1 edge during CALC → next cycle BUSY=0, Q=0, REM=0, no VALID. A following 1000/10 → Q=100, REM=0.
